// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main control FSM for the multicycle RV64I core.
// Sequences fetch, decode, execute, memory and write-back, drives the datapath
// selects and enables, and guards every memory access with a wait-state counter
// that traps when the memory stalls for too long.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state
);

    // State encodings are visible on the debug port, so they are fixed values.
    localparam logic [3:0] StReset  = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StExecR  = 4'd3;
    localparam logic [3:0] StExecI  = 4'd4;
    localparam logic [3:0] StAddr   = 4'd5;
    localparam logic [3:0] StMemRd  = 4'd6;
    localparam logic [3:0] StMemWr  = 4'd7;
    localparam logic [3:0] StWbAlu  = 4'd8;
    localparam logic [3:0] StWbMem  = 4'd9;
    localparam logic [3:0] StBranch = 4'd10;
    localparam logic [3:0] StJal    = 4'd11;
    localparam logic [3:0] StJalr   = 4'd12;
    localparam logic [3:0] StLui    = 4'd13;
    localparam logic [3:0] StTrap   = 4'd15;

    // Opcodes (instr[6:0]).
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    // Datapath select values.
    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcARs1   = 2'd1;
    localparam logic [1:0] SrcAZero  = 2'd2;
    localparam logic [1:0] SrcBRs2   = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] AluAdd    = 2'd0;
    localparam logic [1:0] AluSub    = 2'd1;
    localparam logic [1:0] AluFunct  = 2'd2;
    localparam logic [1:0] WbAluOut  = 2'd0;
    localparam logic [1:0] WbMem     = 2'd1;
    localparam logic [1:0] WbPc4     = 2'd2;
    localparam logic [1:0] PcAlu     = 2'd0;
    localparam logic [1:0] PcAluOut  = 2'd1;
    localparam logic [1:0] PcAluJalr = 2'd2;

    // Trap causes.
    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseIllegal = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;

    localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       trap_q, trap_d;
    logic [1:0] trap_cause_q, trap_cause_d;
    logic [1:0] enter_cause;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       in_mem_state;
    logic       timeout;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // Only opcode and funct3 steer the FSM; the rest of the word is for the datapath.
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) ||
                          (state_q == StMemWr);
    // A ready in the limit cycle still completes: timeout needs mem_ready low.
    assign timeout = in_mem_state && !mem_ready && (wait_cnt_q == WaitLimit);

    // Next-state selection and trap cause on entry to TRAP.
    always_comb begin
        state_d     = state_q;
        enter_cause = CauseNone;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d     = StTrap;
                    enter_cause = CauseTimeout;
                end
            end
            StDecode: begin
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpI:              state_d = StExecI;
                    OpLoad, OpStore:  state_d = StAddr;
                    OpBranch:         state_d = StBranch;
                    OpJal:            state_d = StJal;
                    OpJalr:           state_d = StJalr;
                    OpLui:            state_d = StLui;
                    default: begin
                        state_d     = StTrap;
                        enter_cause = CauseIllegal;
                    end
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StAddr:  state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StWbMem;
                end else if (timeout) begin
                    state_d     = StTrap;
                    enter_cause = CauseTimeout;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (timeout) begin
                    state_d     = StTrap;
                    enter_cause = CauseTimeout;
                end
            end
            StWbAlu, StWbMem, StJal, StLui: state_d = StFetch;
            StBranch: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    state_d = StFetch;
                end else begin
                    state_d     = StTrap;
                    enter_cause = CauseIllegal;
                end
            end
            StJalr: begin
                if (funct3 == 3'b000) begin
                    state_d = StFetch;
                end else begin
                    state_d     = StTrap;
                    enter_cause = CauseIllegal;
                end
            end
            StTrap: state_d = StTrap;
            // Unused encoding: treat as corruption and park in TRAP.
            default: begin
                state_d     = StTrap;
                enter_cause = CauseIllegal;
            end
        endcase
    end

    // Wait counter restarts on every state change and counts stalled memory cycles.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (in_mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Sticky trap flag and cause, captured on the first entry to TRAP.
    always_comb begin
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        if (!trap_q && state_d == StTrap) begin
            trap_d       = 1'b1;
            trap_cause_d = enter_cause;
        end
    end

    // State registers; reset drops the FSM to RESET immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReset;
            wait_cnt_q   <= 8'd0;
            trap_q       <= 1'b0;
            trap_cause_q <= CauseNone;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Moore outputs decoded from state, qualified by mem_ready/alu_zero/funct3.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src_a = SrcAPc;
        alu_src_b = SrcBRs2;
        alu_op    = AluAdd;
        wb_sel    = WbAluOut;
        pc_sel    = PcAlu;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_a = SrcAPc;
                alu_src_b = SrcBFour;
                alu_op    = AluAdd;
                pc_sel    = PcAlu;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_a = SrcAPc;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluFunct;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
            end
            StAddr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
            end
            StMemRd: mem_read = 1'b1;
            StMemWr: mem_write = 1'b1;
            StWbAlu: begin
                reg_write = 1'b1;
                wb_sel    = WbAluOut;
            end
            StWbMem: begin
                reg_write = 1'b1;
                wb_sel    = WbMem;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluSub;
                pc_sel    = PcAluOut;
                if (funct3 == 3'b000) begin
                    pc_write = alu_zero;
                end else if (funct3 == 3'b001) begin
                    pc_write = !alu_zero;
                end
            end
            StJal: begin
                reg_write = 1'b1;
                wb_sel    = WbPc4;
                pc_sel    = PcAluOut;
                pc_write  = 1'b1;
            end
            StJalr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                pc_sel    = PcAluJalr;
                wb_sel    = WbPc4;
                // A malformed jalr must not update architectural state.
                if (funct3 == 3'b000) begin
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                end
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                reg_write = 1'b1;
                wb_sel    = WbAluOut;
            end
            default: ;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of the multicycle control FSM, plus
// hand-written sequences for traps, wait-state timeout and asynchronous reset.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel, pc_sel;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LD   = 32'h0000B283;
    localparam logic [31:0] I_SD   = 32'h0050B423;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BBAD = 32'h0020A463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_JALR = 32'h000100E7;
    localparam logic [31:0] I_JBAD = 32'h000110E7;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .pc_sel     (pc_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        alu_zero;
        logic        mem_ready;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    // Expected packed output word with trap clear.
    function automatic logic [21:0] ex(input int st, input int pcw, input int irw,
                                       input int mrd, input int mwr, input int rw,
                                       input int sa, input int sb, input int op,
                                       input int wb, input int ps);
        logic [3:0] s4;
        s4 = st[3:0];
        return {pcw[0], irw[0], mrd[0], mwr[0], rw[0], sa[1:0], sb[1:0], op[1:0],
                wb[1:0], ps[1:0], 1'b0, 2'b00, s4};
    endfunction

    function automatic logic [21:0] actual();
        return {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a, alu_src_b,
                alu_op, wb_sel, pc_sel, trap, trap_cause, state};
    endfunction

    task automatic push(input logic [31:0] i, input logic az, input logic mr,
                        input logic [21:0] e);
        vecs[nv].instr     = i;
        vecs[nv].alu_zero  = az;
        vecs[nv].mem_ready = mr;
        vecs[nv].exp       = e;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        instr     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH, fetch instruction i with ready memory and leave DECODE.
    task automatic fetch_decode(input logic [31:0] i);
        instr     = i;
        mem_ready = 1'b1;
        tick();
        tick();
    endtask

    logic [21:0] f_ok, f_wait, dec, wb_alu;
    int          fetch_cycles;

    initial begin
        instr     = 32'h0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        rst_n     = 1'b0;

        f_ok   = ex(1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        f_wait = ex(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        dec    = ex(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        wb_alu = ex(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // One continuous program from reset, one row per cycle.
        push(I_ADDI, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(I_ADDI, 0, 1, f_ok);
        push(I_ADDI, 0, 1, dec);
        push(I_ADDI, 0, 1, ex(4, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
        push(I_ADDI, 0, 1, wb_alu);
        push(I_ADD,  0, 1, f_ok);
        push(I_ADD,  0, 1, dec);
        push(I_ADD,  0, 1, ex(3, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        push(I_ADD,  0, 1, wb_alu);
        push(I_LD,   0, 0, f_wait);
        push(I_LD,   0, 1, f_ok);
        push(I_LD,   0, 1, dec);
        push(I_LD,   0, 1, ex(5, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        push(I_LD,   0, 0, ex(6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(I_LD,   0, 0, ex(6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(I_LD,   0, 0, ex(6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(I_LD,   0, 1, ex(6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(I_LD,   0, 1, ex(9, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        push(I_SD,   0, 1, f_ok);
        push(I_SD,   0, 1, dec);
        push(I_SD,   0, 1, ex(5, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        push(I_SD,   0, 1, ex(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        push(I_BEQ,  1, 1, f_ok);
        push(I_BEQ,  1, 1, dec);
        push(I_BEQ,  1, 1, ex(10, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        push(I_BEQ,  0, 1, f_ok);
        push(I_BEQ,  0, 1, dec);
        push(I_BEQ,  0, 1, ex(10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        push(I_BNE,  1, 1, f_ok);
        push(I_BNE,  1, 1, dec);
        push(I_BNE,  1, 1, ex(10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        push(I_BNE,  0, 1, f_ok);
        push(I_BNE,  0, 1, dec);
        push(I_BNE,  0, 1, ex(10, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
        push(I_JAL,  0, 1, f_ok);
        push(I_JAL,  0, 1, dec);
        push(I_JAL,  0, 1, ex(11, 1, 0, 0, 0, 1, 0, 0, 0, 2, 1));
        push(I_JALR, 0, 1, f_ok);
        push(I_JALR, 0, 1, dec);
        push(I_JALR, 0, 1, ex(12, 1, 0, 0, 0, 1, 1, 2, 0, 2, 2));
        push(I_LUI,  0, 1, f_ok);
        push(I_LUI,  0, 1, dec);
        push(I_LUI,  0, 1, ex(13, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0));
        push(I_ADDI, 0, 1, f_ok);

        do_reset();
        for (int i = 0; i < nv; i++) begin
            instr     = vecs[i].instr;
            alu_zero  = vecs[i].alu_zero;
            mem_ready = vecs[i].mem_ready;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
            tick();
        end

        // Branch with unsupported funct3: no PC write, then illegal trap.
        do_reset();
        tick();
        fetch_decode(I_BBAD);
        alu_zero = 1'b1;
        @(negedge clk);
        chk("bbad_state", 32'(state), 32'd10);
        chk("bbad_pcw", 32'(pc_write), 32'd0);
        tick();
        @(negedge clk);
        chk("bbad_trap", 32'({trap, trap_cause, state}), 32'({1'b1, 2'd1, 4'd15}));

        // jalr with funct3 != 000: no writes, then illegal trap.
        do_reset();
        tick();
        fetch_decode(I_JBAD);
        @(negedge clk);
        chk("jbad_state", 32'(state), 32'd12);
        chk("jbad_we", 32'({pc_write, reg_write}), 32'd0);
        tick();
        @(negedge clk);
        chk("jbad_trap", 32'({trap, trap_cause, state}), 32'({1'b1, 2'd1, 4'd15}));

        // Illegal opcode: trap is sticky for 20 cycles, reset clears it at once.
        do_reset();
        tick();
        fetch_decode(I_ILL);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("ill_hold%0d", i),
                32'({trap, trap_cause, state, pc_write, ir_write, mem_read, reg_write}),
                32'({1'b1, 2'd1, 4'd15, 4'b0000}));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("ill_rst", 32'({trap, trap_cause, state}), 32'd0);
        #1;
        rst_n = 1'b1;

        // Fetch timeout: 16 stalled FETCH cycles, then TRAP with cause 2.
        do_reset();
        tick();
        fetch_cycles = 0;
        mem_ready    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state == 4'd15) break;
            if (state == 4'd1) fetch_cycles++;
            tick();
        end
        chk("to_cycles", 32'(fetch_cycles), 32'd16);
        chk("to_trap", 32'({trap, trap_cause, state}), 32'({1'b1, 2'd2, 4'd15}));

        // Ready on the 16th FETCH cycle wins over the timeout.
        do_reset();
        tick();
        for (int i = 1; i <= 16; i++) begin
            mem_ready = (i == 16);
            tick();
        end
        @(negedge clk);
        chk("late_ok", 32'({trap, trap_cause, state}), 32'({1'b0, 2'd0, 4'd2}));

        // Asynchronous reset while waiting in MEM_WR drops mem_write with no edge.
        do_reset();
        tick();
        fetch_decode(I_SD);
        mem_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("mw_pre", 32'({state, mem_write}), 32'({4'd7, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("mw_rst", 32'({state, mem_write}), 32'({4'd0, 1'b0}));
        #2;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
